// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared helpers and constants for sync_fifo_param.
//   fifo_depth() : words held for a given address width
//   level_w()    : bits needed to count 0..DEPTH inclusive
//   th_legal()   : threshold range check, evaluated at elaboration
//   RST_LEVEL    : reset water level (flags decode from it, so it also
//                  defines the reset flag state: empty/almost_empty high)
//   RST_PULSE    : reset value of rd_valid and the error pulses
package fifo_pkg;

   localparam int   RST_LEVEL = 0;
   localparam logic RST_PULSE = 1'b0;

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

   // DEPTH itself must be representable, hence DEPTH+1 values.
   function automatic int level_w(input int addr_w);
      return $clog2(fifo_depth(addr_w) + 1);
   endfunction

   function automatic bit th_legal(input int addr_w, input int afull_th,
                                   input int aempty_th);
      return (afull_th >= 1) && (afull_th <= fifo_depth(addr_w)) &&
             (aempty_th >= 0) && (aempty_th <= fifo_depth(addr_w) - 1);
   endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram -- DATA_W x 2**ADDR_W simple dual-port RAM.
//   clk, rst_n        : clock, async active-low reset (read register only;
//                       the array itself is never cleared)
//   we, waddr, wdata  : write port
//   re, raddr, rdata  : read port. REG_RD=1 gives a registered read
//                       (rdata updates the edge after re); REG_RD=0 gives a
//                       combinational tap of mem[raddr], re ignored.
module fifo_sdp_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter bit REG_RD = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   generate
      if (REG_RD) begin : g_reg_rd
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  rdata <= '0;
            else if (re) rdata <= mem[raddr];
         end
      end else begin : g_tap_rd
         assign rdata = mem[raddr];
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param -- single-clock FIFO with water level, programmable
// almost-full/almost-empty thresholds and overflow/underflow pulses.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
// (rd_data is a combinational view of the head word, rd_valid = !empty);
// otherwise reads have one registered cycle of latency.
// Ports:
//   sys_clk, sys_rst_n     : clock, async active-low reset
//   wr_en, wr_data         : push request (ignored while full)
//   rd_en                  : pop request (ignored while empty)
//   rd_data, rd_valid      : read data and its qualifier
//   full, empty            : level == DEPTH / level == 0
//   almost_full            : level >= AFULL_TH
//   almost_empty           : level <= AEMPTY_TH
//   water_level            : words stored, 0..DEPTH
//   overflow, underflow    : one-cycle pulse after a rejected push / pop
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int AFULL_TH  = 252,
   parameter int AEMPTY_TH = 4
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   water_level,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = fifo_depth(ADDR_W);
   localparam int LW    = level_w(ADDR_W);
   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_TH);
   localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_TH);

   generate
      if (!th_legal(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_bad_th
         $error("sync_fifo_param: AFULL_TH/AEMPTY_TH out of range");
      end
   endgenerate

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0]     level;
   logic              wr_acc, rd_acc;

   // Acceptance uses the flags of the current (pre-edge) level, so a
   // simultaneous pair at full keeps only the pop, at empty only the push.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // Level alone tells full from empty; pointers are free-running mod DEPTH.
   assign full         = (level == DEPTH_L);
   assign empty        = (level == '0);
   assign almost_full  = (level >= AFULL_L);
   assign almost_empty = (level <= AEMPTY_L);
   assign water_level  = level;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= LW'(RST_LEVEL);
         overflow  <= RST_PULSE;
         underflow <= RST_PULSE;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

`ifdef FIFO_FWFT_EN
   fifo_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_RD(1'b0)) u_ram (
      .clk(sys_clk), .rst_n(sys_rst_n),
      .we(wr_acc), .waddr(wr_ptr), .wdata(wr_data),
      .re(rd_acc), .raddr(rd_ptr), .rdata(rd_data)
   );

   // Head word is presented whenever something is stored; rd_en only pops.
   assign rd_valid = !empty;
`else
   logic rd_valid_q;

   fifo_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_RD(1'b1)) u_ram (
      .clk(sys_clk), .rst_n(sys_rst_n),
      .we(wr_acc), .waddr(wr_ptr), .wdata(wr_data),
      .re(rd_acc), .raddr(rd_ptr), .rdata(rd_data)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rd_valid_q <= RST_PULSE;
      else            rd_valid_q <= rd_acc;
   end

   assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param -- randomized and directed checks of sync_fifo_param
// (standard read mode, default parameters) against a queue-based model.
module tb_sync_fifo_param;

   localparam int DW = 8, AW = 8, DEPTH = 256, AF = 252, AE = 4;

   logic          sys_clk = 1'b0, sys_rst_n = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid, full, empty, almost_full, almost_empty;
   logic          overflow, underflow;
   logic [AW:0]   water_level;

   sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .water_level(water_level),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0, bad = 0;

   // Reference model: contents as a queue plus the last observable outputs.
   logic [DW-1:0] q[$];
   logic          m_rv, m_ovf, m_unf;
   logic [DW-1:0] m_rd;

   function automatic void model_clear();
      q.delete();
      m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_rd = '0;
   endfunction

   // Apply one cycle of requests, advance the model, return at edge+1.
   task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re);
      bit was_full, was_empty;
      wr_en = we; wr_data = wd; rd_en = re;
      @(posedge sys_clk);
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ovf = we && was_full;
      m_unf = re && was_empty;
      m_rv  = re && !was_empty;
      if (m_rv) m_rd = q.pop_front();
      if (we && !was_full) q.push_back(wd);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic apply_reset();
      sys_rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      model_clear();
      repeat (2) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      model_clear();
      repeat (2) @(posedge sys_clk);
      #1;
      total++;
      if ({empty, almost_empty, full, almost_full, rd_valid, overflow, underflow} !== 7'b1100000) begin
         bad++; $display("FAIL reset_flags: got %b want 1100000",
            {empty, almost_empty, full, almost_full, rd_valid, overflow, underflow});
      end
      total++;
      if (water_level !== '0 || rd_data !== '0) begin
         bad++; $display("FAIL reset_level_data: got lvl=%0d data=%h want 0/00", water_level, rd_data);
      end
      sys_rst_n = 1'b1;
      drive(1'b0, '0, 1'b0);
      total++;
      if ({empty, almost_empty, full, almost_full, rd_valid} !== 5'b11000 || water_level !== '0) begin
         bad++; $display("FAIL reset_release: got %b lvl=%0d want 11000 lvl=0",
            {empty, almost_empty, full, almost_full, rd_valid}, water_level);
      end
   endtask

   task automatic test_fill();
      for (int k = 1; k <= DEPTH; k++) begin
         drive(1'b1, DW'(k - 1), 1'b0);
         total++;
         if (water_level !== (AW+1)'(k) || almost_full !== (k >= AF) ||
             full !== (k == DEPTH) || empty !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL fill_%0d: got lvl=%0d af=%b f=%b e=%b ov=%b", k,
               water_level, almost_full, full, empty, overflow);
         end
      end
      drive(1'b1, 8'hEE, 1'b0);
      total++;
      if (overflow !== 1'b1 || water_level !== (AW+1)'(DEPTH) || full !== 1'b1) begin
         bad++; $display("FAIL overflow: got ov=%b lvl=%0d f=%b want 1/256/1", overflow, water_level, full);
      end
      drive(1'b0, '0, 1'b0);
      total++;
      if (overflow !== 1'b0) begin
         bad++; $display("FAIL overflow_pulse: got %b want 0", overflow);
      end
   endtask

   task automatic test_drain();
      for (int k = 0; k < DEPTH; k++) begin
         drive(1'b0, '0, 1'b1);
         total++;
         if (rd_valid !== 1'b1 || rd_data !== DW'(k) ||
             water_level !== (AW+1)'(DEPTH - 1 - k) ||
             almost_empty !== ((DEPTH - 1 - k) <= AE) || empty !== (k == DEPTH - 1)) begin
            bad++; $display("FAIL drain_%0d: got v=%b d=%h lvl=%0d ae=%b e=%b", k,
               rd_valid, rd_data, water_level, almost_empty, empty);
         end
      end
      drive(1'b0, '0, 1'b0);
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 8'hFF) begin
         bad++; $display("FAIL read_hold: got v=%b d=%h want 0/ff", rd_valid, rd_data);
      end
      drive(1'b0, '0, 1'b1);
      total++;
      if (underflow !== 1'b1 || rd_valid !== 1'b0 || water_level !== '0) begin
         bad++; $display("FAIL underflow: got uf=%b v=%b lvl=%0d want 1/0/0", underflow, rd_valid, water_level);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      apply_reset();
      for (int k = 0; k < 10; k++) drive(1'b1, DW'(n++), 1'b0);
      for (int k = 0; k < 600; k++) begin
         drive(1'b1, DW'(n++), 1'b1);
         total++;
         if (water_level !== 9'd10 || rd_valid !== 1'b1 || rd_data !== DW'(k)) begin
            bad++; $display("FAIL b2b_%0d: got lvl=%0d v=%b d=%h want 10/1/%h", k,
               water_level, rd_valid, rd_data, DW'(k));
         end
      end
      while (q.size() < DEPTH) drive(1'b1, DW'(n++), 1'b0);
      drive(1'b1, 8'h77, 1'b1);
      total++;
      if (water_level !== 9'd255 || overflow !== 1'b1 || rd_valid !== 1'b1 || rd_data !== m_rd) begin
         bad++; $display("FAIL full_rdwr: got lvl=%0d ov=%b v=%b d=%h want 255/1/1/%h",
            water_level, overflow, rd_valid, rd_data, m_rd);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int k = 0; k < 100; k++) drive(1'b1, DW'($urandom), 1'b0);
      #2 sys_rst_n = 1'b0;
      #1;
      model_clear();
      total++;
      if (empty !== 1'b1 || water_level !== '0 || full !== 1'b0) begin
         bad++; $display("FAIL reset_mid: got e=%b lvl=%0d want 1/0", empty, water_level);
      end
      #2 sys_rst_n = 1'b1;
      drive(1'b1, 8'h5A, 1'b0);
      drive(1'b0, '0, 1'b1);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h5A || empty !== 1'b1) begin
         bad++; $display("FAIL reset_mid_data: got v=%b d=%h e=%b want 1/5a/1", rd_valid, rd_data, empty);
      end
   endtask

   task automatic test_random();
      int pw, pr, sz;
      logic [6:0] exp_fl;
      apply_reset();
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) begin
            pw = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
         end
         drive(($urandom % 100) < pw, DW'($urandom), ($urandom % 100) < pr);
         sz = q.size();
         exp_fl = {sz == DEPTH, sz == 0, sz >= AF, sz <= AE, m_rv, m_ovf, m_unf};
         total++;
         if ({full, empty, almost_full, almost_empty, rd_valid, overflow, underflow} !== exp_fl ||
             water_level !== (AW+1)'(sz) || rd_data !== m_rd) begin
            bad++; $display("FAIL random_%0d: got fl=%b lvl=%0d d=%h want fl=%b lvl=%0d d=%h", c,
               {full, empty, almost_full, almost_empty, rd_valid, overflow, underflow},
               water_level, rd_data, exp_fl, sz, m_rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
